// File: rtl/msrh_pkg.sv
// Shared types for the branch-tag allocator: tag/pointer widths and FSM states.
// Default sizes mirror the core configuration (16 snapshot slots, 5-wide dispatch).
package msrh_pkg;
  localparam int RV_BRU_ENTRY_SIZE = 16;
  localparam int CONF_DISP_SIZE    = 5;
  localparam int BRTAG_W           = $clog2(RV_BRU_ENTRY_SIZE);

  typedef logic [BRTAG_W-1:0] brtag_t;
  typedef logic [BRTAG_W:0]   brtag_ptr_t;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_RESTORE = 1'b1
  } brtag_state_t;
endpackage

// File: rtl/msrh_brtag_age_mask.sv
// Marks the valid snapshot slots that are younger than a given tag, using tail-relative age.
// Also returns the tag's own age so the caller can rebuild the head pointer.
module msrh_brtag_age_mask
  import msrh_pkg::*;
#(
  parameter  int ENTRY_SIZE = RV_BRU_ENTRY_SIZE,
  localparam int TAG_W      = $clog2(ENTRY_SIZE),
  localparam int PTR_W      = TAG_W + 1
) (
  input  logic [PTR_W-1:0]      tail,
  input  logic [PTR_W-1:0]      head,
  input  logic [TAG_W-1:0]      tag,
  input  logic [ENTRY_SIZE-1:0] valid,
  output logic [ENTRY_SIZE-1:0] mask,
  output logic [TAG_W-1:0]      tag_age
);

  logic [PTR_W-1:0] occupancy;
  logic [TAG_W-1:0] slot_age;

  always_comb begin
    occupancy = head - tail;
    tag_age   = tag - tail[TAG_W-1:0];
    slot_age  = '0;
    mask      = '0;
    for (int j = 0; j < ENTRY_SIZE; j++) begin
      slot_age = TAG_W'(j) - tail[TAG_W-1:0];
      mask[j]  = valid[j] && (slot_age > tag_age) && ({1'b0, slot_age} < occupancy);
    end
  end

endmodule

// File: rtl/msrh_brtag_alloc_ctrl.sv
// Branch-tag allocator: hands out snapshot slots in dispatch order, retires them in order,
// and sequences the one-cycle rename restore on mispredict. Optional MSRH_BRTAG_PERF_CNT_EN adds perf counters.
module msrh_brtag_alloc_ctrl
  import msrh_pkg::*;
#(
  parameter  int ENTRY_SIZE = RV_BRU_ENTRY_SIZE,
  parameter  int DISP_SIZE  = CONF_DISP_SIZE,
  localparam int TAG_W      = $clog2(ENTRY_SIZE),
  localparam int PTR_W      = TAG_W + 1,
  localparam int CNT_W      = $clog2(DISP_SIZE + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic [DISP_SIZE-1:0] i_disp_valid,
  input  logic [DISP_SIZE-1:0] i_disp_is_br,
  output logic                 o_disp_ready,
  output logic [TAG_W-1:0]     o_brtag [DISP_SIZE],
  output logic [DISP_SIZE-1:0] o_snap_load,
  input  logic                 i_br_upd_valid,
  input  logic [TAG_W-1:0]     i_br_upd_brtag,
  input  logic                 i_br_upd_mispredict,
  output logic                 o_restore_valid,
  output logic [TAG_W-1:0]     o_restore_brtag,
  output logic [PTR_W-1:0]     o_free_count
`ifdef MSRH_BRTAG_PERF_CNT_EN
  ,
  output logic [31:0]          o_perf_full_stall,
  output logic [31:0]          o_perf_restore,
  output logic [31:0]          o_perf_alloc
`endif
);

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, occupancy;
  logic [ENTRY_SIZE-1:0] valid_q, valid_d, resolved_q, resolved_d, kill_mask;
  logic [TAG_W-1:0]      restore_tag_q, tag_age, tag_offset, tail_idx;
  logic [DISP_SIZE-1:0]  br_req;
  logic [CNT_W-1:0]      alloc_num;
  logic                  mispredict, retire;
  brtag_state_t          state_q, state_d;

  msrh_brtag_age_mask #(.ENTRY_SIZE(ENTRY_SIZE)) u_age_mask (
    .tail    (tail_q),
    .head    (head_q),
    .tag     (i_br_upd_brtag),
    .valid   (valid_q),
    .mask    (kill_mask),
    .tag_age (tag_age)
  );

  // Tags are handed out densely from head in ascending dispatch-slot order.
  always_comb begin
    br_req     = i_disp_valid & i_disp_is_br;
    alloc_num  = '0;
    tag_offset = '0;
    for (int i = 0; i < DISP_SIZE; i++) begin
      o_brtag[i] = head_q[TAG_W-1:0] + tag_offset;
      tag_offset = tag_offset + TAG_W'(br_req[i]);
      alloc_num  = alloc_num + CNT_W'(br_req[i]);
    end
    occupancy    = head_q - tail_q;
    o_free_count = PTR_W'(ENTRY_SIZE) - occupancy;
    tail_idx     = tail_q[TAG_W-1:0];
    mispredict   = i_br_upd_valid && i_br_upd_mispredict && valid_q[i_br_upd_brtag];
    retire       = valid_q[tail_idx] && resolved_q[tail_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_NORMAL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = ST_NORMAL;
    if (!i_flush && mispredict) state_d = ST_RESTORE;
  end

  always_comb begin
    o_restore_valid = (state_q == ST_RESTORE);
    o_restore_brtag = restore_tag_q;
    o_disp_ready    = (state_q == ST_NORMAL) && (32'(o_free_count) >= 32'(alloc_num))
                      && !i_flush && !mispredict;
    o_snap_load     = br_req & {DISP_SIZE{o_disp_ready}};
  end

  // Retire clears after resolve so a slot never leaves stale resolved state behind.
  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (i_br_upd_valid && valid_q[i_br_upd_brtag]) resolved_d[i_br_upd_brtag] = 1'b1;
    if (mispredict) begin
      valid_d    = valid_d & ~kill_mask;
      resolved_d = resolved_d & ~kill_mask;
      head_d     = tail_q + PTR_W'(tag_age) + PTR_W'(1);
    end
    if (retire) begin
      valid_d[tail_idx]    = 1'b0;
      resolved_d[tail_idx] = 1'b0;
      tail_d               = tail_q + PTR_W'(1);
    end
    if (o_disp_ready) begin
      for (int i = 0; i < DISP_SIZE; i++) begin
        if (br_req[i]) begin
          valid_d[o_brtag[i]]    = 1'b1;
          resolved_d[o_brtag[i]] = 1'b0;
        end
      end
      head_d = head_q + PTR_W'(alloc_num);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                     restore_tag_q <= '0;
    else if (mispredict && !i_flush) restore_tag_q <= i_br_upd_brtag;
  end

`ifdef MSRH_BRTAG_PERF_CNT_EN
  logic [31:0] full_stall_q, restore_q, alloc_q;
  logic [32:0] alloc_sum;

  assign alloc_sum = {1'b0, alloc_q} + 33'(alloc_num);

  // A full stall is a cycle where only the lack of free slots held the group back.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      full_stall_q <= '0;
      restore_q    <= '0;
      alloc_q      <= '0;
    end else begin
      if (state_q == ST_NORMAL && !i_flush && !mispredict && !o_disp_ready && full_stall_q != '1)
        full_stall_q <= full_stall_q + 32'd1;
      if (state_q == ST_RESTORE && restore_q != '1)
        restore_q <= restore_q + 32'd1;
      if (o_disp_ready)
        alloc_q <= alloc_sum[32] ? '1 : alloc_sum[31:0];
    end
  end

  assign o_perf_full_stall = full_stall_q;
  assign o_perf_restore    = restore_q;
  assign o_perf_alloc      = alloc_q;
`endif

endmodule

// File: tb/tb_msrh_brtag_alloc_ctrl.sv
// Directed bench for msrh_brtag_alloc_ctrl: a ring-free model (unbounded head/tail counts)
// checks every cycle, and literal expectations pin the model on the documented scenarios.
module tb_msrh_brtag_alloc_ctrl;
  import msrh_pkg::*;

  localparam int ES = 16;
  localparam int DS = 5;

  logic          i_clk = 1'b0;
  logic          i_reset, i_flush, i_br_upd_valid, i_br_upd_mispredict;
  logic [DS-1:0] i_disp_valid, i_disp_is_br, o_snap_load;
  brtag_t        i_br_upd_brtag, o_restore_brtag;
  brtag_t        o_brtag [DS];
  logic          o_disp_ready, o_restore_valid;
  brtag_ptr_t    o_free_count;
`ifdef MSRH_BRTAG_PERF_CNT_EN
  logic [31:0]   o_perf_full_stall, o_perf_restore, o_perf_alloc;
`endif

  always #5 i_clk = ~i_clk;

  msrh_brtag_alloc_ctrl dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_flush             (i_flush),
    .i_disp_valid        (i_disp_valid),
    .i_disp_is_br        (i_disp_is_br),
    .o_disp_ready        (o_disp_ready),
    .o_brtag             (o_brtag),
    .o_snap_load         (o_snap_load),
    .i_br_upd_valid      (i_br_upd_valid),
    .i_br_upd_brtag      (i_br_upd_brtag),
    .i_br_upd_mispredict (i_br_upd_mispredict),
    .o_restore_valid     (o_restore_valid),
    .o_restore_brtag     (o_restore_brtag),
`ifdef MSRH_BRTAG_PERF_CNT_EN
    .o_perf_full_stall   (o_perf_full_stall),
    .o_perf_restore      (o_perf_restore),
    .o_perf_alloc        (o_perf_alloc),
`endif
    .o_free_count        (o_free_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: head/tail are plain allocation/retirement counts, slot index is count mod ES.
  int m_head = 0, m_tail = 0, m_restore_tag = 0;
  bit m_restore = 1'b0;
  bit m_valid [ES];
  bit m_res   [ES];
  bit exp_ready, exp_misp;
  int exp_n;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    int free, k;
    logic [DS-1:0] br;
    br       = i_disp_valid & i_disp_is_br;
    exp_n    = $countones(br);
    exp_misp = i_br_upd_valid && i_br_upd_mispredict && m_valid[i_br_upd_brtag];
    free     = ES - (m_head - m_tail);
    exp_ready = !m_restore && free >= exp_n && !i_flush && !exp_misp;
    checkValue("disp_ready", 32'(o_disp_ready), 32'(exp_ready));
    checkValue("snap_load", 32'(o_snap_load), exp_ready ? 32'(br) : 32'd0);
    checkValue("free_count", 32'(o_free_count), 32'(free));
    checkValue("restore_valid", 32'(o_restore_valid), 32'(m_restore));
    checkValue("restore_brtag", 32'(o_restore_brtag), 32'(m_restore_tag));
    k = 0;
    for (int i = 0; i < DS; i++) begin
      if (br[i]) begin
        if (exp_ready) checkValue($sformatf("brtag[%0d]", i), 32'(o_brtag[i]), 32'((m_head + k) % ES));
        k++;
      end
    end
  endtask

  task automatic modelStep();
    int occ, age, tslot;
    bit ret;
    if (i_reset || i_flush) begin
      for (int s = 0; s < ES; s++) begin m_valid[s] = 0; m_res[s] = 0; end
      m_head = 0; m_tail = 0; m_restore = 0;
      if (i_reset) m_restore_tag = 0;
    end else begin
      occ   = m_head - m_tail;
      tslot = m_tail % ES;
      ret   = m_valid[tslot] && m_res[tslot];
      if (i_br_upd_valid && m_valid[i_br_upd_brtag]) m_res[i_br_upd_brtag] = 1;
      if (exp_misp) begin
        age = 0;
        for (int a = 0; a < occ; a++) if ((m_tail + a) % ES == int'(i_br_upd_brtag)) age = a;
        for (int a = age + 1; a < occ; a++) begin
          m_valid[(m_tail + a) % ES] = 0;
          m_res[(m_tail + a) % ES]   = 0;
        end
        m_head = m_tail + age + 1;
      end
      if (ret) begin
        m_valid[tslot] = 0; m_res[tslot] = 0; m_tail++;
      end
      if (exp_ready) begin
        for (int k = 0; k < exp_n; k++) begin
          m_valid[(m_head + k) % ES] = 1; m_res[(m_head + k) % ES] = 0;
        end
        m_head += exp_n;
      end
      m_restore = exp_misp;
      if (exp_misp) m_restore_tag = int'(i_br_upd_brtag);
    end
  endtask

  task automatic applyStimulus(input logic [DS-1:0] v, input logic [DS-1:0] b, input bit uv,
                               input int ut, input bit um, input bit fl, input bit rs);
    @(negedge i_clk);
    i_disp_valid = v; i_disp_is_br = b;
    i_br_upd_valid = uv; i_br_upd_brtag = brtag_t'(ut); i_br_upd_mispredict = um;
    i_flush = fl; i_reset = rs;
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int s = 0; s < ES; s++) begin m_valid[s] = 0; m_res[s] = 0; end
    i_reset = 1; i_flush = 0; i_disp_valid = '0; i_disp_is_br = '0;
    i_br_upd_valid = 0; i_br_upd_brtag = '0; i_br_upd_mispredict = 0;
    repeat (2) @(posedge i_clk);

    // Reset values and first group: branches in slots 0,2,4.
    idle(1);
    checkValue("rst_free", 32'(o_free_count), 32'd16);
    checkValue("rst_ready", 32'(o_disp_ready), 32'd1);
    checkValue("rst_restore", 32'(o_restore_valid), 32'd0);
    applyStimulus(5'b11111, 5'b10101, 0, 0, 0, 0, 0);
    checkValue("g1_snap", 32'(o_snap_load), 32'b10101);
    checkValue("g1_tag0", 32'(o_brtag[0]), 32'd0);
    checkValue("g1_tag2", 32'(o_brtag[2]), 32'd1);
    checkValue("g1_tag4", 32'(o_brtag[4]), 32'd2);
    idle(1);
    checkValue("g1_free", 32'(o_free_count), 32'd13);
    applyStimulus('0, '0, 0, 0, 0, 1, 0);

    // Fill 15, then a 2-branch group waits for tag 0 to resolve and retire.
    repeat (3) applyStimulus(5'b11111, 5'b11111, 0, 0, 0, 0, 0);
    applyStimulus(5'b00011, 5'b00011, 1, 0, 0, 0, 0);
    checkValue("full_ready_t0", 32'(o_disp_ready), 32'd0);
    applyStimulus(5'b00011, 5'b00011, 0, 0, 0, 0, 0);
    checkValue("full_ready_t1", 32'(o_disp_ready), 32'd0);
    applyStimulus(5'b00011, 5'b00011, 0, 0, 0, 0, 0);
    checkValue("full_ready_t2", 32'(o_disp_ready), 32'd1);
    checkValue("wrap_tag0", 32'(o_brtag[0]), 32'd15);
    checkValue("wrap_tag1", 32'(o_brtag[1]), 32'd0);
    applyStimulus('0, '0, 0, 0, 0, 1, 0);

    // Allocate 0..5, mispredict tag 2.
    applyStimulus(5'b11111, 5'b11111, 0, 0, 0, 0, 0);
    applyStimulus(5'b00001, 5'b00001, 0, 0, 0, 0, 0);
    applyStimulus('0, '0, 1, 2, 1, 0, 0);
    applyStimulus(5'b00001, 5'b00001, 0, 0, 0, 0, 0);
    checkValue("misp_restore", 32'(o_restore_valid), 32'd1);
    checkValue("misp_rtag", 32'(o_restore_brtag), 32'd2);
    checkValue("misp_block", 32'(o_disp_ready), 32'd0);
    checkValue("misp_free", 32'(o_free_count), 32'd13);
    applyStimulus(5'b00001, 5'b00001, 0, 0, 0, 0, 0);
    checkValue("post_ready", 32'(o_disp_ready), 32'd1);
    checkValue("post_tag", 32'(o_brtag[0]), 32'd3);
    applyStimulus('0, '0, 0, 0, 0, 1, 0);

    // Out-of-order resolution: tail must wait for tag 0.
    applyStimulus(5'b11111, 5'b11111, 0, 0, 0, 0, 0);
    applyStimulus('0, '0, 1, 3, 0, 0, 0);
    idle(2);
    checkValue("ooo_free", 32'(o_free_count), 32'd11);
    applyStimulus('0, '0, 1, 0, 0, 0, 0);
    applyStimulus('0, '0, 1, 1, 0, 0, 0);
    applyStimulus('0, '0, 1, 2, 0, 0, 0);
    idle(4);
    checkValue("ooo_free_end", 32'(o_free_count), 32'd15);
    applyStimulus('0, '0, 0, 0, 0, 1, 0);

    // Mispredict beats a dispatch group; a later mispredict on a killed tag is ignored.
    applyStimulus(5'b11111, 5'b11111, 0, 0, 0, 0, 0);
    applyStimulus(5'b11111, 5'b11111, 1, 1, 1, 0, 0);
    checkValue("mw_ready", 32'(o_disp_ready), 32'd0);
    checkValue("mw_snap", 32'(o_snap_load), 32'd0);
    applyStimulus('0, '0, 1, 3, 1, 0, 0);
    idle(1);
    checkValue("kill_norestore", 32'(o_restore_valid), 32'd0);
    checkValue("kill_free", 32'(o_free_count), 32'd14);
    applyStimulus('0, '0, 0, 0, 0, 1, 0);

    // Flush with a restore pending, then reset in the middle of RESTORE.
    applyStimulus(5'b11111, 5'b11111, 0, 0, 0, 0, 0);
    applyStimulus(5'b00111, 5'b00111, 0, 0, 0, 0, 0);
    applyStimulus('0, '0, 1, 3, 1, 1, 0);
    idle(1);
    checkValue("flush_free", 32'(o_free_count), 32'd16);
    checkValue("flush_norestore", 32'(o_restore_valid), 32'd0);
    applyStimulus(5'b00111, 5'b00111, 0, 0, 0, 0, 0);
    applyStimulus('0, '0, 1, 1, 1, 0, 0);
    applyStimulus('0, '0, 0, 0, 0, 0, 1);
    idle(1);
    checkValue("rst2_free", 32'(o_free_count), 32'd16);
    checkValue("rst2_ready", 32'(o_disp_ready), 32'd1);
    checkValue("rst2_restore", 32'(o_restore_valid), 32'd0);
    checkValue("rst2_rtag", 32'(o_restore_brtag), 32'd0);

    // Mixed traffic, checked against the model every cycle.
    for (int i = 0; i < 200; i++)
      applyStimulus(DS'($urandom), DS'($urandom), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, ES - 1)), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 40) == 0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
